// File: rtl/bf16_accum_seq.sv
// bf16_accum_seq: sequences a bfloat16 element stream through an external registered adder, producing per-vector sums.
module bf16_accum_seq #(
  parameter int ADD_LAT = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  input  logic [15:0]      add_sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [15:0]      sum_data,
  output logic [CNT_W-1:0] sum_count,
  output logic             sum_nan
);
  typedef enum logic [1:0] {IDLE, ACC, WAIT, DONE} state_t;
  state_t           r_state;
  logic [15:0]      r_acc, r_add_a, r_add_b, r_sum_data;
  logic [3:0]       r_cnt;
  logic             r_last, r_sum_valid, r_sum_nan;
  logic [CNT_W-1:0] r_sum_count;
  logic             w_xfer, w_nan;
  logic [CNT_W-1:0] w_cnt_inc;
  assign in_ready  = !rst && (r_state == IDLE || r_state == ACC);
  assign w_xfer    = in_valid && in_ready;
  assign w_nan     = &in_data[14:7];
  assign w_cnt_inc = &r_sum_count ? r_sum_count : r_sum_count + 1'b1;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign sum_valid = r_sum_valid;
  assign sum_data  = r_sum_data;
  assign sum_count = r_sum_count;
  assign sum_nan   = r_sum_nan;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_sum_data  <= '0;
      r_cnt       <= '0;
      r_last      <= 1'b0;
      r_sum_valid <= 1'b0;
      r_sum_nan   <= 1'b0;
      r_sum_count <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_xfer) begin
          r_acc       <= in_data;
          r_sum_count <= CNT_W'(1);
          r_sum_nan   <= w_nan;
          if (in_last) begin
            r_sum_data  <= in_data;
            r_sum_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_state <= ACC;
          end
        end
        ACC: if (w_xfer) begin
          r_add_a     <= r_acc;
          r_add_b     <= in_data;
          r_last      <= in_last;
          r_sum_count <= w_cnt_inc;
          r_sum_nan   <= r_sum_nan | w_nan;
          r_cnt       <= 4'(ADD_LAT);
          r_state     <= WAIT;
        end
        // operands stay put until the adder result has settled
        WAIT: if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end else begin
          r_acc <= add_sum;
          if (r_last) begin
            r_sum_data  <= add_sum;
            r_sum_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_state <= ACC;
          end
        end
        DONE: if (sum_ready) begin
          r_sum_valid <= 1'b0;
          r_sum_count <= '0;
          r_sum_nan   <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
